// File: rtl/oldland_tlb.sv
// oldland_tlb: fully associative TLB, 1-cycle lookup, round-robin victim, global invalidate
// Ports: clk/rst (async high); enabled/translate/virt lookup request;
//        phys/valid/access held lookup result; complete/miss result pulses;
//        miss_virt faulting page; load_en/load_virt/load_phys/load_access entry load;
//        inval/inval_complete invalidate-all and its acknowledge pulse.
module oldland_tlb #(
  parameter int NUM_ENTRIES = 8,
  localparam int ENTRY_BITS = $clog2(NUM_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        translate,
  input  logic [19:0] virt,
  output logic [19:0] phys,
  output logic        valid,
  output logic [1:0]  access,
  output logic        complete,
  output logic        miss,
  output logic [19:0] miss_virt,
  input  logic        load_en,
  input  logic [19:0] load_virt,
  input  logic [19:0] load_phys,
  input  logic [1:0]  load_access,
  input  logic        inval,
  output logic        inval_complete
);
  logic [NUM_ENTRIES-1:0] ent_valid_q, ent_valid_d;
  logic [19:0] ent_tag_q [NUM_ENTRIES];
  logic [19:0] ent_phys_q [NUM_ENTRIES];
  logic [1:0] ent_acc_q [NUM_ENTRIES];
  logic [ENTRY_BITS-1:0] victim_q, victim_d, ld_idx, wr_idx;
  logic hit, ld_hit, lk_hit;
  logic [19:0] hit_phys;
  logic [1:0] hit_acc;
  logic [19:0] phys_q, phys_d, miss_virt_q, miss_virt_d;
  logic [1:0] access_q, access_d;
  logic valid_q, valid_d, complete_q, complete_d, miss_q, miss_d, ic_q;
  // Tags are unique, so OR-reducing the matching entries selects exactly one.
  always_comb begin
    hit = 1'b0;
    hit_phys = '0;
    hit_acc = '0;
    ld_hit = 1'b0;
    ld_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_valid_q[i] && ent_tag_q[i] == virt) begin
        hit = 1'b1;
        hit_phys |= ent_phys_q[i];
        hit_acc |= ent_acc_q[i];
      end
      if (ent_valid_q[i] && ent_tag_q[i] == load_virt) begin
        ld_hit = 1'b1;
        ld_idx |= ENTRY_BITS'(i);
      end
    end
  end
  // A reload of an existing page overwrites in place so tags stay unique.
  always_comb begin
    wr_idx = ld_hit ? ld_idx : victim_q;
    victim_d = inval ? '0 : (load_en && !ld_hit) ? victim_q + 1'b1 : victim_q;
    ent_valid_d = inval ? '0 : load_en ? ent_valid_q | (NUM_ENTRIES'(1) << wr_idx) : ent_valid_q;
    lk_hit = !enabled || hit;
    phys_d = !translate ? phys_q : !enabled ? virt : hit ? hit_phys : phys_q;
    access_d = !translate ? access_q : !enabled ? 2'b11 : hit ? hit_acc : access_q;
    valid_d = translate ? lk_hit : valid_q;
    complete_d = translate && lk_hit;
    miss_d = translate && !lk_hit;
    miss_virt_d = miss_d ? virt : miss_virt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid_q <= '0;
      victim_q <= '0;
      phys_q <= '0;
      access_q <= '0;
      valid_q <= 1'b0;
      complete_q <= 1'b0;
      miss_q <= 1'b0;
      miss_virt_q <= '0;
      ic_q <= 1'b0;
    end else begin
      ent_valid_q <= ent_valid_d;
      victim_q <= victim_d;
      phys_q <= phys_d;
      access_q <= access_d;
      valid_q <= valid_d;
      complete_q <= complete_d;
      miss_q <= miss_d;
      miss_virt_q <= miss_virt_d;
      ic_q <= inval;
    end
  end
  // Entry payload needs no reset: it is meaningless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (load_en && !inval) begin
      ent_tag_q[wr_idx] <= load_virt;
      ent_phys_q[wr_idx] <= load_phys;
      ent_acc_q[wr_idx] <= load_access;
    end
  end
  assign phys = phys_q;
  assign access = access_q;
  assign valid = valid_q;
  assign complete = complete_q;
  assign miss = miss_q;
  assign miss_virt = miss_virt_q;
  assign inval_complete = ic_q;
endmodule

// File: tb/tb_oldland_tlb.sv
// tb_oldland_tlb: directed and randomized checks of oldland_tlb against a behavioural model
module tb_oldland_tlb;
  localparam int N = 8;
  logic clk = 0, rst = 1, enabled = 0, translate = 0, load_en = 0, inval = 0;
  logic [19:0] virt = 0, load_virt = 0, load_phys = 0;
  logic [1:0] load_access = 0;
  logic [19:0] phys, miss_virt;
  logic [1:0] access;
  logic valid, complete, miss, inval_complete;
  int tests = 0, fails = 0;
  oldland_tlb #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .translate(translate), .virt(virt),
    .phys(phys), .valid(valid), .access(access), .complete(complete), .miss(miss),
    .miss_virt(miss_virt), .load_en(load_en), .load_virt(load_virt), .load_phys(load_phys),
    .load_access(load_access), .inval(inval), .inval_complete(inval_complete)
  );
  always #5 clk = ~clk;
  // model: list of loaded pages plus the position of the next replacement
  logic m_v [N];
  logic [19:0] m_t [N], m_p [N];
  logic [1:0] m_a [N];
  int m_vic;
  logic [19:0] e_phys, e_mvirt;
  logic [1:0] e_acc;
  logic e_valid, e_comp, e_miss, e_ic;
  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    for (int i = 0; i < N; i++) m_v[i] = 0;
    m_vic = 0;
    e_phys = 0; e_mvirt = 0; e_acc = 0;
    e_valid = 0; e_comp = 0; e_miss = 0; e_ic = 0;
  endtask
  function automatic int find(input logic [19:0] page);
    for (int i = 0; i < N; i++) if (m_v[i] && m_t[i] == page) return i;
    return -1;
  endfunction
  task automatic model_step;
    int f;
    e_comp = 0; e_miss = 0; e_ic = inval;
    if (translate) begin
      f = find(virt);
      if (!enabled) begin
        e_phys = virt; e_acc = 2'b11; e_valid = 1; e_comp = 1;
      end else if (f >= 0) begin
        e_phys = m_p[f]; e_acc = m_a[f]; e_valid = 1; e_comp = 1;
      end else begin
        e_valid = 0; e_miss = 1; e_mvirt = virt;
      end
    end
    if (inval) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_vic = 0;
    end else if (load_en) begin
      f = find(load_virt);
      if (f < 0) begin
        f = m_vic;
        m_vic = (m_vic + 1) % N;
      end
      m_v[f] = 1; m_t[f] = load_virt; m_p[f] = load_phys; m_a[f] = load_access;
    end
  endtask
  task automatic verify_all;
    check("phys", phys, e_phys);
    check("access", 20'(access), 20'(e_acc));
    check("valid", 20'(valid), 20'(e_valid));
    check("complete", 20'(complete), 20'(e_comp));
    check("miss", 20'(miss), 20'(e_miss));
    check("miss_virt", miss_virt, e_mvirt);
    check("inval_complete", 20'(inval_complete), 20'(e_ic));
  endtask
  task automatic cycle;
    model_step;
    @(posedge clk);
    #1;
    verify_all;
  endtask
  task automatic drive(input logic tr, input logic [19:0] v, input logic ld, input logic [19:0] lv,
                       input logic [19:0] lp, input logic [1:0] la, input logic inv);
    translate = tr; virt = v; load_en = ld; load_virt = lv; load_phys = lp; load_access = la; inval = inv;
  endtask
  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic look(input logic [19:0] v);
    drive(1, v, 0, 0, 0, 0, 0);
    cycle;
  endtask
  task automatic load(input logic [19:0] v, input logic [19:0] p, input logic [1:0] a);
    drive(0, 0, 1, v, p, a, 0);
    cycle;
  endtask
  task automatic flush;
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle;
  endtask
  initial begin
    model_reset;
    #12;
    verify_all;
    @(negedge clk);
    rst = 0;
    enabled = 0;
    look(20'h12345);
    check("bypass_phys", phys, 20'h12345);
    check("bypass_acc", 20'(access), 20'h3);
    check("bypass_comp", 20'(complete), 20'h1);
    check("bypass_miss", 20'(miss), 20'h0);
    enabled = 1;
    load(20'h00400, 20'h80001, 2'b01);
    look(20'h00400);
    check("hit_phys", phys, 20'h80001);
    check("hit_acc", 20'(access), 20'h1);
    check("hit_comp", 20'(complete), 20'h1);
    idle;
    repeat (5) begin
      cycle;
      check("hold_phys", phys, 20'h80001);
    end
    flush;
    look(20'hABCDE);
    check("miss_pulse", 20'(miss), 20'h1);
    check("miss_valid", 20'(valid), 20'h0);
    check("miss_page", miss_virt, 20'hABCDE);
    idle;
    cycle;
    check("miss_low", 20'(miss), 20'h0);
    flush;
    for (int p = 0; p < 9; p++) load(20'(p), 20'(p + 'h100), 2'(p));
    for (int p = 0; p < 9; p++) begin
      look(20'(p));
      check("fill_hit", 20'(complete), 20'(p != 0));
    end
    load(20'h5, 20'h00055, 2'b10);
    look(20'h5);
    check("reload_phys", phys, 20'h00055);
    look(20'h1);
    check("reload_keep", phys, 20'h101);
    flush;
    for (int p = 10; p < 13; p++) load(20'(p), 20'(p), 2'b11);
    drive(0, 0, 1, 20'h7, 20'h7, 2'b11, 1);
    cycle;
    check("inval_pulse", 20'(inval_complete), 20'h1);
    idle;
    cycle;
    check("inval_low", 20'(inval_complete), 20'h0);
    look(20'h7);
    check("inval_drop", 20'(miss), 20'h1);
    for (int p = 10; p < 13; p++) look(20'(p));
    repeat (3000) begin
      enabled = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 1) == 1, 20'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
            20'($urandom_range(0, 15)), 20'($urandom), 2'($urandom), $urandom_range(0, 15) == 0);
      cycle;
    end
    enabled = 1;
    flush;
    load(20'h3, 20'h33, 2'b11);
    drive(1, 20'h3, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1;
    #1;
    model_reset;
    verify_all;
    idle;
    @(negedge clk);
    rst = 0;
    look(20'h3);
    check("post_rst_miss", 20'(miss), 20'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
